mc_controller_hs: RTL

Parametrised multi-cycle MIPS control unit with a memory ready/request handshake, replacing the fixed-latency main decoder/ALU decoder pair. It sits between the instruction register fields and the datapath and drives every datapath enable and mux select. It extends the instruction set with BNE, SLTI, ANDI and ORI, and optionally J. It adds wait states, a memory timeout, illegal-instruction trapping and a retired-instruction counter.

---
 rtl/mc_controller_hs_if.sv | 49 ++++
 rtl/mc_controller_hs.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_hs_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_hs_if
// Description : Instruction-field, memory handshake and datapath-control
//               bundle between the multi-cycle controller and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_controller_hs_if #(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int RETIRE_W = 32
);
    logic [OP_W-1:0]     OP;
    logic [FUNCT_W-1:0]  Funct;
    logic                Zero;
    logic                MemReady;
    logic                MemReq;
    logic                PCEn;
    logic                IRWrite;
    logic                RegWrite;
    logic                MemWrite;
    logic                ALUSrcA;
    logic                IorD;
    logic                MemtoReg;
    logic                RegDst;
    logic                ImmZero;
    logic [1:0]          ALUSrcB;
    logic [1:0]          PCSrc;
    logic [2:0]          ALUControl;
    logic                Fault;
    logic                FaultCause;
    logic [RETIRE_W-1:0] Retired;
    logic [3:0]          State;

    modport master (
        input  OP, Funct, Zero, MemReady,
        output MemReq, PCEn, IRWrite, RegWrite, MemWrite, ALUSrcA, IorD,
               MemtoReg, RegDst, ImmZero, ALUSrcB, PCSrc, ALUControl,
               Fault, FaultCause, Retired, State
    );

    modport slave (
        output OP, Funct, Zero, MemReady,
        input  MemReq, PCEn, IRWrite, RegWrite, MemWrite, ALUSrcA, IorD,
               MemtoReg, RegDst, ImmZero, ALUSrcB, PCSrc, ALUControl,
               Fault, FaultCause, Retired, State
    );
endinterface
`default_nettype wire

// File: rtl/mc_controller_hs.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller_hs
// Description : Multi-cycle MIPS control FSM with memory ready handshake,
//               wait timeout, illegal-op trap and retired counter.
//               Define MCC_JUMP_EN to build the J instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller_hs #(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int TIMEOUT  = 15,
    parameter int RETIRE_W = 32
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    mc_controller_hs_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
        S_FAULT   = 4'd12
    } state_t;

    localparam logic [OP_W-1:0]    c_OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    c_OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    c_OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    c_OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    c_OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0]    c_OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0]    c_OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0]    c_OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0]    c_OP_ORI   = OP_W'(6'b001101);
`ifdef MCC_JUMP_EN
    localparam logic [OP_W-1:0]    c_OP_J     = OP_W'(6'b000010);
`endif
    localparam logic [FUNCT_W-1:0] c_FN_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] c_FN_SUB   = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] c_FN_AND   = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] c_FN_OR    = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] c_FN_SLT   = FUNCT_W'(6'b101010);

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_next;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [RETIRE_W-1:0]   r_retired;
    logic                  r_fault;
    logic                  r_fault_cause;

    logic       w_cause;
    logic       w_in_wait;
    logic       w_retire;
    logic       w_funct_ok;
    logic       w_mem_req, w_pc_en, w_ir_write, w_reg_write, w_mem_write;
    logic       w_alu_src_a, w_iord, w_memto_reg, w_reg_dst, w_imm_zero;
    logic [1:0] w_alu_src_b, w_pc_src;
    logic [2:0] w_alu_ctrl;

    assign w_funct_ok = (bus.Funct == c_FN_ADD) || (bus.Funct == c_FN_SUB) ||
                        (bus.Funct == c_FN_AND) || (bus.Funct == c_FN_OR)  ||
                        (bus.Funct == c_FN_SLT);

    assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

    assign w_retire  = (r_state == S_MEMWB) || (r_state == S_MEMWR && bus.MemReady) ||
                       (r_state == S_ALUWB) || (r_state == S_BRANCH) ||
                       (r_state == S_IWB)   || (r_state == S_JUMP);

    always_comb begin
        w_next      = r_state;
        w_cause     = 1'b0;
        w_mem_req   = 1'b0;
        w_pc_en     = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_alu_src_a = 1'b0;
        w_iord      = 1'b0;
        w_memto_reg = 1'b0;
        w_reg_dst   = 1'b0;
        w_imm_zero  = 1'b0;
        w_alu_src_b = 2'b00;
        w_pc_src    = 2'b00;
        w_alu_ctrl  = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_ctrl  = c_ALU_ADD;
                w_ir_write  = bus.MemReady;
                w_pc_en     = bus.MemReady;
                if (bus.MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                w_alu_ctrl  = c_ALU_ADD;
                if (bus.OP == c_OP_LW || bus.OP == c_OP_SW)
                    w_next = S_MEMADR;
                else if (bus.OP == c_OP_RTYPE && w_funct_ok)
                    w_next = S_EXECUTE;
                else if (bus.OP == c_OP_BEQ || bus.OP == c_OP_BNE)
                    w_next = S_BRANCH;
                else if (bus.OP == c_OP_ADDI || bus.OP == c_OP_SLTI ||
                         bus.OP == c_OP_ANDI || bus.OP == c_OP_ORI)
                    w_next = S_IEXEC;
`ifdef MCC_JUMP_EN
                else if (bus.OP == c_OP_J)
                    w_next = S_JUMP;
`endif
                else begin
                    w_next  = S_FAULT;
                    w_cause = 1'b1;
                end
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_ctrl  = c_ALU_ADD;
                w_next      = (bus.OP == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                if (bus.MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                w_memto_reg = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_req   = 1'b1;
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
                if (bus.MemReady) w_next = S_FETCH;
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                case (bus.Funct)
                    c_FN_SUB: w_alu_ctrl = c_ALU_SUB;
                    c_FN_AND: w_alu_ctrl = c_ALU_AND;
                    c_FN_OR:  w_alu_ctrl = c_ALU_OR;
                    c_FN_SLT: w_alu_ctrl = c_ALU_SLT;
                    default:  w_alu_ctrl = c_ALU_ADD;
                endcase
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_ctrl  = c_ALU_SUB;
                w_pc_src    = 2'b01;
                w_pc_en     = (bus.OP == c_OP_BNE) ? ~bus.Zero : bus.Zero;
                w_next      = S_FETCH;
            end
            S_IEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                case (bus.OP)
                    c_OP_SLTI: w_alu_ctrl = c_ALU_SLT;
                    c_OP_ANDI: w_alu_ctrl = c_ALU_AND;
                    c_OP_ORI:  w_alu_ctrl = c_ALU_OR;
                    default:   w_alu_ctrl = c_ALU_ADD;
                endcase
                w_imm_zero = (bus.OP == c_OP_ANDI) || (bus.OP == c_OP_ORI);
                w_next     = S_IWB;
            end
            S_IWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
`ifdef MCC_JUMP_EN
            S_JUMP: begin
                w_pc_src = 2'b10;
                w_pc_en  = 1'b1;
                w_next   = S_FETCH;
            end
`endif
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
        // A ready in the last allowed cycle completes the access instead of faulting
        if (w_in_wait && !bus.MemReady && r_wait_cnt == c_WAIT_LAST) begin
            w_next  = S_FAULT;
            w_cause = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_FETCH;
            r_wait_cnt    <= '0;
            r_retired     <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_in_wait && !bus.MemReady)
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            if (w_retire)
                r_retired <= r_retired + RETIRE_W'(1);
            if (w_next == S_FAULT && r_state != S_FAULT) begin
                r_fault       <= 1'b1;
                r_fault_cause <= w_cause;
            end
        end
    end

    assign bus.MemReq     = w_mem_req;
    assign bus.PCEn       = w_pc_en;
    assign bus.IRWrite    = w_ir_write;
    assign bus.RegWrite   = w_reg_write;
    assign bus.MemWrite   = w_mem_write;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.IorD       = w_iord;
    assign bus.MemtoReg   = w_memto_reg;
    assign bus.RegDst     = w_reg_dst;
    assign bus.ImmZero    = w_imm_zero;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.PCSrc      = w_pc_src;
    assign bus.ALUControl = w_alu_ctrl;
    assign bus.Fault      = r_fault;
    assign bus.FaultCause = r_fault_cause;
    assign bus.Retired    = r_retired;
    assign bus.State      = r_state;
endmodule
`default_nettype wire
